// File: rtl/conv1_requant_writer.sv
// conv1 requantisation writer: per-channel bias, scale, rounding shift and ReLU clamp on
// four lanes, packing 32 output bytes into two 128-bit beats for the feature-map buffer.
module conv1_requant_writer #(
  parameter int NUM_COLS = 32,
  parameter int ACC_BITS = 32,
  parameter int A_BITS   = 8,
  parameter int ADDR_W   = 19,
  parameter int LANES    = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         frame_start,
  input  logic [ADDR_W-1:0]            out_base,
  input  logic [ADDR_W-1:0]            num_pix,
  input  logic [7:0]                   relu_max,
  input  logic                         param_we,
  input  logic [5:0]                   param_idx,
  input  logic [31:0]                  param_bias,
  input  logic [15:0]                  param_mult,
  input  logic [4:0]                   param_shift,
  input  logic                         y_valid,
  input  logic [NUM_COLS*ACC_BITS-1:0] y_data,
  input  logic                         y_tile_sel,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [127:0]                 wr_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic [1:0]                   err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_WR0  = 2'd2;
  localparam logic [1:0] ST_WR1  = 2'd3;
  localparam logic [3:0] NUM_GROUPS = 4'd8;
  localparam logic [3:0] CALC_LAST  = 4'd10;
  localparam int BUF_W  = NUM_COLS * A_BITS;
  localparam int BEAT_W = BUF_W / 2;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [31:0] bias);
    logic [32:0] sum;
    sum = {acc[31], acc} + {bias[31], bias};
    if (sum[32] != sum[31]) begin
      sat_add32 = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      sat_add32 = sum[31:0];
    end
  endfunction

  function automatic logic [47:0] scale48(input logic [31:0] s, input logic [15:0] mult);
    scale48 = $signed({{16{s[31]}}, s}) * $signed({32'd0, mult});
  endfunction

  function automatic logic [7:0] round_clamp(input logic [47:0] p, input logic [4:0] shift,
                                             input logic [7:0] ceil);
    logic signed [48:0] rnd;
    logic signed [48:0] sum;
    logic signed [48:0] r;
    rnd = (shift == 5'd0) ? 49'sd0 : (49'sd1 <<< (shift - 5'd1));
    sum = $signed({p[47], p}) + rnd;
    r   = sum >>> shift;
    if (r < 49'sd0) begin
      round_clamp = 8'd0;
    end else if (r > $signed({41'd0, ceil})) begin
      round_clamp = ceil;
    end else begin
      round_clamp = r[7:0];
    end
  endfunction

  logic [1:0]                   state_r, state_nx_s;
  logic [3:0]                   cnt_r;
  logic [NUM_COLS*ACC_BITS-1:0] acc_r;
  logic                         tile_r;
  logic [ADDR_W-1:0]            base_r, num_pix_r, pix_cnt_r, pend_base_r, pend_num_r;
  logic                         fs_pend_r;
  logic                         fs_eff_s;
  logic                         issue_s;
  logic [31:0]                  bias_mem_r  [64];
  logic [15:0]                  mult_mem_r  [64];
  logic [4:0]                   shift_mem_r [64];
  logic                         s1_vld_r, s2_vld_r;
  logic [2:0]                   s1_grp_r, s2_grp_r;
  logic [31:0]                  s1_val_r  [LANES];
  logic [47:0]                  s2_prod_r [LANES];
  logic [31:0]                  s1_nx_s   [LANES];
  logic [47:0]                  s2_nx_s   [LANES];
  logic [7:0]                   s3_byte_s [LANES];
  logic [BUF_W-1:0]             buf_r;
  logic                         wr_valid_r, busy_r, frame_done_r;
  logic [ADDR_W-1:0]            wr_addr_r;
  logic [127:0]                 wr_data_r;
  logic [1:0]                   err_r;

  assign issue_s  = (state_r == ST_CALC) && (cnt_r < NUM_GROUPS);
  assign fs_eff_s = frame_start | fs_pend_r;

  // Next-state logic for the vector FSM
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (y_valid) state_nx_s = ST_CALC; else state_nx_s = ST_IDLE;
      ST_CALC: if (cnt_r == CALC_LAST) state_nx_s = ST_WR0; else state_nx_s = ST_CALC;
      ST_WR0:  if (wr_ready) state_nx_s = ST_WR1; else state_nx_s = ST_WR0;
      ST_WR1:  if (wr_ready) state_nx_s = ST_IDLE; else state_nx_s = ST_WR1;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Per-lane arithmetic; the table is frozen outside IDLE so each stage indexes it directly
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      s1_nx_s[l]   = sat_add32(acc_r[(int'(cnt_r[2:0]) * LANES + l) * ACC_BITS +: ACC_BITS],
                               bias_mem_r[{tile_r, cnt_r[2:0], 2'(l)}]);
      s2_nx_s[l]   = scale48(s1_val_r[l], mult_mem_r[{tile_r, s1_grp_r, 2'(l)}]);
      s3_byte_s[l] = round_clamp(s2_prod_r[l], shift_mem_r[{tile_r, s2_grp_r, 2'(l)}], relu_max);
    end
  end

  // Channel parameter register file, writable only while idle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 64; i++) begin
        bias_mem_r[i]  <= 32'd0;
        mult_mem_r[i]  <= 16'd0;
        shift_mem_r[i] <= 5'd0;
      end
    end else if (param_we && (state_r == ST_IDLE)) begin
      bias_mem_r[param_idx]  <= param_bias;
      mult_mem_r[param_idx]  <= param_mult;
      shift_mem_r[param_idx] <= param_shift;
    end
  end

  // Lane pipeline registers and the 32-byte output buffer
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1_vld_r <= 1'b0;
      s2_vld_r <= 1'b0;
      s1_grp_r <= 3'd0;
      s2_grp_r <= 3'd0;
      buf_r    <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_val_r[l]  <= 32'd0;
        s2_prod_r[l] <= 48'd0;
      end
    end else begin
      s1_vld_r <= issue_s;
      s1_grp_r <= cnt_r[2:0];
      s2_vld_r <= s1_vld_r;
      s2_grp_r <= s1_grp_r;
      for (int l = 0; l < LANES; l++) begin
        s1_val_r[l]  <= s1_nx_s[l];
        s2_prod_r[l] <= s2_nx_s[l];
        if (s2_vld_r) begin
          buf_r[(int'(s2_grp_r) * LANES + l) * A_BITS +: A_BITS] <= s3_byte_s[l];
        end
      end
    end
  end

  // Control FSM, pixel/frame bookkeeping and the registered write port
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      acc_r        <= '0;
      tile_r       <= 1'b0;
      base_r       <= '0;
      num_pix_r    <= '0;
      pix_cnt_r    <= '0;
      fs_pend_r    <= 1'b0;
      pend_base_r  <= '0;
      pend_num_r   <= '0;
      wr_valid_r   <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= 128'd0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 2'b00;
    end else begin
      state_r      <= state_nx_s;
      busy_r       <= (state_nx_s != ST_IDLE);
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Counter clear lands before the vector captured this cycle, making it pixel 0
          if (fs_eff_s) begin
            pix_cnt_r <= '0;
            err_r     <= 2'b00;
            base_r    <= frame_start ? out_base : pend_base_r;
            num_pix_r <= frame_start ? num_pix : pend_num_r;
            fs_pend_r <= 1'b0;
          end
          if (y_valid) begin
            acc_r  <= y_data;
            tile_r <= y_tile_sel;
            cnt_r  <= 4'd0;
          end
        end
        ST_CALC: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == CALC_LAST) begin
            wr_valid_r <= 1'b1;
            wr_addr_r  <= base_r + {pix_cnt_r[ADDR_W-2:0], 1'b0};
            wr_data_r  <= buf_r[BEAT_W-1:0];
          end
        end
        ST_WR0: begin
          if (wr_ready) begin
            wr_addr_r <= wr_addr_r + ADDR_ONE;
            wr_data_r <= buf_r[BUF_W-1:BEAT_W];
          end
        end
        ST_WR1: begin
          if (wr_ready) begin
            wr_valid_r <= 1'b0;
            if ((num_pix_r != '0) && (pix_cnt_r == num_pix_r - ADDR_ONE)) begin
              pix_cnt_r    <= '0;
              frame_done_r <= 1'b1;
            end else begin
              pix_cnt_r <= pix_cnt_r + ADDR_ONE;
            end
          end
        end
        default: cnt_r <= 4'd0;
      endcase
      if (state_r != ST_IDLE) begin
        err_r <= err_r | {param_we, y_valid};
        if (frame_start) begin
          fs_pend_r   <= 1'b1;
          pend_base_r <= out_base;
          pend_num_r  <= num_pix;
        end
      end
    end
  end

  assign wr_valid   = wr_valid_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_conv1_requant_writer.sv
// Scoreboard bench for conv1_requant_writer: directed vectors push expected beats,
// a forked monitor pops and compares every accepted write beat.
module tb_conv1_requant_writer;
  localparam int ADDR_W = 19;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              frame_start, param_we, y_valid, y_tile_sel, wr_ready;
  logic [ADDR_W-1:0] out_base, num_pix;
  logic [7:0]        relu_max;
  logic [5:0]        param_idx;
  logic [31:0]       param_bias;
  logic [15:0]       param_mult;
  logic [4:0]        param_shift;
  logic [1023:0]     y_data;
  logic              wr_valid, busy, frame_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0]      wr_data;
  logic [1:0]        err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [127:0]      data;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;
  int fd_count = 0;

  always #5 CLK = ~CLK;

  conv1_requant_writer dut (
    .CLK(CLK), .RESET(RESET), .frame_start(frame_start), .out_base(out_base),
    .num_pix(num_pix), .relu_max(relu_max), .param_we(param_we), .param_idx(param_idx),
    .param_bias(param_bias), .param_mult(param_mult), .param_shift(param_shift),
    .y_valid(y_valid), .y_data(y_data), .y_tile_sel(y_tile_sel), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1) begin
        if (frame_done === 1'b1) fd_count++;
        if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: beat addr %0h data %0h, none required", wr_addr, wr_data);
          end else begin
            e = sb.pop_front();
            chk("sb_addr", {237'd0, wr_addr}, {237'd0, e.addr});
            chk("sb_data", {128'd0, wr_data}, {128'd0, e.data});
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fstart(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    frame_start = 1'b1; out_base = b; num_pix = n;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pwrite(input logic [5:0] idx, input logic [31:0] b, input logic [15:0] m,
                        input logic [4:0] s);
    param_we = 1'b1; param_idx = idx; param_bias = b; param_mult = m; param_shift = s;
    step();
    param_we = 1'b0;
  endtask

  task automatic send(input logic [1023:0] d, input logic tile);
    y_valid = 1'b1; y_data = d; y_tile_sel = tile;
    step();
    y_valid = 1'b0;
  endtask

  task automatic push_vec(input logic [ADDR_W-1:0] a, input logic [255:0] e);
    sb.push_back('{addr: a, data: e[127:0]});
    sb.push_back('{addr: a + 19'd1, data: e[255:128]});
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      step();
      n++;
    end while (busy !== 1'b0 && n < 60);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  function automatic logic [1023:0] vec_a();
    logic [1023:0] v = '0;
    v[0*32  +: 32] = 32'd50;
    v[1*32  +: 32] = 32'd1000;
    v[2*32  +: 32] = 32'h7FFF_FFFF;
    v[3*32  +: 32] = 32'd1000;
    v[20*32 +: 32] = 32'd77;
    v[31*32 +: 32] = 32'd10;
    return v;
  endfunction

  initial begin
    logic [1023:0] v;
    logic [255:0]  e, exp_a255, exp_a6, exp_bank;
    frame_start = 1'b0; out_base = '0; num_pix = '0; relu_max = 8'd255;
    param_we = 1'b0; param_idx = 6'd0; param_bias = 32'd0; param_mult = 16'd0; param_shift = 5'd0;
    y_valid = 1'b0; y_data = '0; y_tile_sel = 1'b0; wr_ready = 1'b1;
    // ch0 150, ch1 (3008>>4)=188, ch2 saturated 255, ch3 negative -> 0, ch20 (155>>1)=77, ch31 (17>>2)=4
    exp_a255 = '0;
    exp_a255[0*8 +: 8] = 8'd150; exp_a255[1*8 +: 8] = 8'd188; exp_a255[2*8 +: 8] = 8'd255;
    exp_a255[20*8 +: 8] = 8'd77; exp_a255[31*8 +: 8] = 8'd4;
    exp_a6 = '0;
    exp_a6[0*8 +: 8] = 8'd6; exp_a6[1*8 +: 8] = 8'd6; exp_a6[2*8 +: 8] = 8'd6;
    exp_a6[20*8 +: 8] = 8'd6; exp_a6[31*8 +: 8] = 8'd4;
    exp_bank = '0;
    exp_bank[7:0] = 8'd50;

    fork
      monitor();
    join_none

    #1 RESET = 1'b0;
    #2;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Basic parameter path and latency
    fstart(19'h100, 19'd0);
    pwrite(6'd0, 32'd100, 16'd1, 5'd0);
    v = '0;
    v[31:0] = 32'd50;
    for (int c = 1; c < 32; c++) v[c*32 +: 32] = 32'hFFFF_FFF6;
    e = '0;
    e[7:0] = 8'h96;
    push_vec(19'h100, e);
    send(v, 1'b0);
    chk("busy_after_e0", busy, 1);
    repeat (10) step();
    chk("wr_valid_e10", wr_valid, 0);
    step();
    chk("wr_valid_e11", wr_valid, 1);
    chk("wr_addr_beat0", wr_addr, 19'h100);
    step();
    chk("wr_addr_beat1", wr_addr, 19'h101);
    step();
    chk("idle_after_e13", {busy, wr_valid}, 2'b00);

    // Rounding, saturation and clamp
    pwrite(6'd1, 32'd0, 16'd3, 5'd4);
    pwrite(6'd2, 32'd1, 16'd1, 5'd0);
    pwrite(6'd3, 32'hFFFF_F830, 16'd1, 5'd0);
    pwrite(6'd20, 32'd0, 16'd2, 5'd1);
    pwrite(6'd31, 32'd5, 16'd1, 5'd2);
    push_vec(19'h102, exp_a255);
    send(vec_a(), 1'b0);
    wait_idle();
    relu_max = 8'd6;
    push_vec(19'h104, exp_a6);
    send(vec_a(), 1'b0);
    wait_idle();
    relu_max = 8'd255;

    // Back-pressure for five cycles on beat 0
    fstart(19'h040, 19'd0);
    wr_ready = 1'b0;
    push_vec(19'h040, exp_a255);
    send(vec_a(), 1'b0);
    repeat (11) step();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", wr_valid, 1);
      chk("stall_addr", wr_addr, 19'h040);
      chk("stall_data", wr_data, exp_a255[127:0]);
      step();
    end
    wr_ready = 1'b1;
    step();
    chk("stall_release_e17", wr_addr, 19'h041);
    wait_idle();

    // Overflow: second y_valid at E5 is dropped
    fstart(19'h080, 19'd0);
    push_vec(19'h080, exp_a255);
    send(vec_a(), 1'b0);
    repeat (4) step();
    y_valid = 1'b1;
    y_data = '1;
    step();
    y_valid = 1'b0;
    wait_idle();
    chk("err_overflow", err, 2'b01);
    fstart(19'h080, 19'd0);
    chk("err_cleared", err, 2'b00);

    // Frame of three pixels
    fstart(19'h200, 19'd3);
    fd_count = 0;
    for (int k = 0; k < 3; k++) begin
      push_vec(19'h200 + 19'(2 * k), exp_a255);
      send(vec_a(), 1'b0);
      wait_idle();
      chk("frame_done_pulse", frame_done, (k == 2) ? 1 : 0);
    end
    push_vec(19'h200, exp_a255);
    send(vec_a(), 1'b0);
    wait_idle();
    chk("frame_done_count", fd_count, 1);

    // Bank select and parameter write while busy
    fstart(19'h300, 19'd0);
    pwrite(6'd32, 32'd0, 16'd1, 5'd0);
    push_vec(19'h300, exp_bank);
    send(vec_a(), 1'b1);
    wait_idle();
    push_vec(19'h302, exp_a255);
    send(vec_a(), 1'b0);
    repeat (2) step();
    pwrite(6'd0, 32'd0, 16'd0, 5'd0);
    wait_idle();
    chk("err_param_busy", err, 2'b10);
    push_vec(19'h304, exp_a255);
    send(vec_a(), 1'b0);
    wait_idle();

    // Asynchronous reset mid-vector
    send(vec_a(), 1'b0);
    repeat (8) step();
    RESET = 1'b0;
    #1;
    chk("midrst_wr_valid", wr_valid, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    push_vec(19'h000, 256'd0);
    send(vec_a(), 1'b0);
    wait_idle();

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
